// File: rtl/matmul_pkg.sv
// Shared constants and FSM encoding for the matrix-multiply operand fetch stage.
package matmul_pkg;

    // Default geometry: 4x4 matrices of 16-bit unsigned words, 1-cycle BRAMs.
    localparam int DEF_N      = 4;
    localparam int DEF_DW     = 16;
    localparam int DEF_AW     = 4;
    localparam int DEF_RD_LAT = 1;

    // Products streamed per full pass (one per i,j,k triple).
    localparam int TOTAL = DEF_N * DEF_N * DEF_N;

    // FSM encoding kept as plain constants so older tools can consume it.
    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t FETCH = 2'd1;
    localparam state_t DRAIN = 2'd2;
    localparam state_t DONE  = 2'd3;

endpackage

// File: rtl/matmul_index_counter.sv
// Nested i/j/k loop counter: k is innermost, all three wrap together.
module matmul_index_counter
    import matmul_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          clr,
    output logic [CW-1:0] i,
    output logic [CW-1:0] j,
    output logic [CW-1:0] k,
    output logic          k_last,
    output logic          all_last
);

    localparam logic [CW-1:0] MAX_IDX = CW'(N - 1);

    logic [CW-1:0] i_q, i_d;
    logic [CW-1:0] j_q, j_d;
    logic [CW-1:0] k_q, k_d;
    logic          j_last;
    logic          i_last;

    assign k_last   = (k_q == MAX_IDX);
    assign j_last   = (j_q == MAX_IDX);
    assign i_last   = (i_q == MAX_IDX);
    assign all_last = k_last & j_last & i_last;

    assign i = i_q;
    assign j = j_q;
    assign k = k_q;

    // Next-index logic: k steps every enabled cycle, j and i carry on wrap.
    always_comb begin
        i_d = i_q;
        j_d = j_q;
        k_d = k_q;
        if (clr) begin
            i_d = '0;
            j_d = '0;
            k_d = '0;
        end else if (en) begin
            if (k_last) begin
                k_d = '0;
                if (j_last) begin
                    j_d = '0;
                    i_d = i_last ? '0 : i_q + 1'b1;
                end else begin
                    j_d = j_q + 1'b1;
                end
            end else begin
                k_d = k_q + 1'b1;
            end
        end
    end

    // Index registers, cleared by the asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i_q <= '0;
            j_q <= '0;
            k_q <= '0;
        end else begin
            i_q <= i_d;
            j_q <= j_d;
            k_q <= k_d;
        end
    end

endmodule

// File: rtl/matmul_operand_fetch.sv
// Walks A and B in i,j,k order, issues BRAM reads and streams registered
// A[i][k]*B[k][j] products tagged with first/last-of-dot-product flags.
module matmul_operand_fetch
    import matmul_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int DW     = DEF_DW,
    parameter int AW     = DEF_AW,
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic [AW-1:0]   addra,
    output logic [AW-1:0]   addrb,
    output logic            ena,
    input  logic [DW-1:0]   douta,
    input  logic [DW-1:0]   doutb,
    output logic [2*DW-1:0] mul_output,
    output logic            mul_valid,
    output logic            mul_first,
    output logic            mul_last,
    output logic            busy,
    output logic            done
);

    localparam int            CW        = (N > 1) ? $clog2(N) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(N * N - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   idx_i, idx_j, idx_k;
    logic            k_last, all_last;
    logic            issue;
    logic            pipe_empty;
    logic [RD_LAT:0] vld_q, vld_d;
    logic [RD_LAT:0] first_q, first_d;
    logic [RD_LAT:0] last_q, last_d;
    logic [2*DW-1:0] mul_output_q, mul_output_d;
    logic [2*DW-1:0] product;
    logic [AW-1:0]   addr_a_calc, addr_b_calc;

    assign issue = (state_q == FETCH);

    matmul_index_counter #(
        .N  (N),
        .CW (CW)
    ) u_index_counter (
        .clk      (clk),
        .reset    (reset),
        .en       (issue),
        .clr      (state_q == IDLE),
        .i        (idx_i),
        .j        (idx_j),
        .k        (idx_k),
        .k_last   (k_last),
        .all_last (all_last)
    );

    // Only the final stage may still hold an issue when the drain completes.
    assign pipe_empty = (vld_q[RD_LAT-1:0] == '0);

    // Control FSM: start is looked at only while idle and never queued.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)      state_d = FETCH;
            FETCH:   if (all_last)   state_d = DRAIN;
            DRAIN:   if (pipe_empty) state_d = DONE;
            DONE:                    state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // Row-major addresses; during drain they park on the final element.
    always_comb begin
        addr_a_calc = AW'(idx_i) * AW'(N) + AW'(idx_k);
        addr_b_calc = AW'(idx_k) * AW'(N) + AW'(idx_j);
        if (state_q == DRAIN) begin
            addra = LAST_ADDR;
            addrb = LAST_ADDR;
        end else begin
            addra = addr_a_calc;
            addrb = addr_b_calc;
        end
    end

    // Tag pipeline follows each issue through the BRAM and product register.
    always_comb begin
        vld_d   = {vld_q[RD_LAT-1:0],   issue};
        first_d = {first_q[RD_LAT-1:0], issue && (idx_k == '0)};
        last_d  = {last_q[RD_LAT-1:0],  issue && k_last};
    end

    // Full-width multiply, captured only when BRAM data belongs to an issue.
    always_comb begin
        product      = (2*DW)'(douta) * (2*DW)'(doutb);
        mul_output_d = vld_q[RD_LAT-1] ? product : mul_output_q;
    end

    // State, tag pipeline and product registers; reset flushes everything.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            vld_q        <= '0;
            first_q      <= '0;
            last_q       <= '0;
            mul_output_q <= '0;
        end else begin
            state_q      <= state_d;
            vld_q        <= vld_d;
            first_q      <= first_d;
            last_q       <= last_d;
            mul_output_q <= mul_output_d;
        end
    end

    assign ena        = issue;
    assign mul_output = mul_output_q;
    assign mul_valid  = vld_q[RD_LAT];
    assign mul_first  = first_q[RD_LAT];
    assign mul_last   = last_q[RD_LAT];
    assign busy       = (state_q == FETCH) || (state_q == DRAIN);
    assign done       = (state_q == DONE);

endmodule
